demux_rr_n: RTL and testbench
=============================

Name: demux_rr_n

Overview:
- Parametrised successor to the fixed 1-to-2 byte demux. Distributes a single valid-qualified input stream round-robin across LANES output lanes, all in one clock domain.
- Each input word is collected into a shadow bank. Once a full group of LANES words has arrived, all lanes are presented together with per-lane valids.
- A flush input emits a partial group with a lane mask.
- Sits between the serial receive path and the per-lane processing stages.

Parameters:
- WIDTH, 8, bits per data word.
- LANES, 2, number of output lanes; legal range 1..16.
- PTR_W, derived localparam = max(1, clog2(LANES)), width of the lane pointer; not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Entrada  input  WIDTH  input data word.
- validEntrada  input  1  Entrada is valid this cycle.
- flush  input  1  emit the partially filled group now.
- Salida  output  LANES*WIDTH  lane data, flattened; lane i occupies bits [i*WIDTH +: WIDTH].
- validsalida  output  LANES  per-lane valid, pulsed for one cycle per emitted group.
- group_done  output  1  one-cycle pulse on every emission (full or flushed).
- lane_idx  output  PTR_W  current write pointer; for debug and verification.

Behaviour:
- Reset: while reset==0, asynchronously clear Salida, validsalida, group_done, lane_idx, the shadow bank and the shadow mask to 0. Deasserting reset resumes operation at lane 0 on the next clock edge. Asserting reset mid-group discards the partial group without emitting it.
- Accept: on an edge with validEntrada==1:
  - write shadow[ptr] <= Entrada and set mask[ptr] <= 1;
  - advance ptr <= ptr+1, wrapping from LANES-1 to 0.
  - When validEntrada==0, ptr, shadow and mask hold.
- Full emission: on the edge that accepts a word into lane LANES-1:
  - Salida <= shadow bank, with lane LANES-1 taken directly from Entrada (not from the shadow);
  - validsalida <= all ones and group_done <= 1;
  - mask clears and ptr returns to 0.
  - Latency: the group is visible in the cycle after the edge accepting its last word.
- Flush emission: on an edge with flush==1 and mask (including any word accepted this edge) nonzero:
  - Salida lanes whose mask bit is set receive their shadow/accepted data; unmasked lanes are driven 0;
  - validsalida <= mask and group_done <= 1;
  - ptr <= 0 and mask clears.
- flush with an empty mask and no valid input: no emission; all outputs keep their previous state apart from the pulses described below.
- flush and validEntrada on the same edge: the word is written at ptr first, then flushed. If ptr==LANES-1 this is identical to a full emission, with validsalida all ones.
- Pulses: validsalida and group_done return to 0 on the next edge unless another emission occurs. Back-to-back emissions on consecutive cycles are legal.
- Salida holds its last emitted value between emissions.
- No backpressure: the downstream block must capture every emission in its pulse cycle.
- LANES==1: every valid word is emitted with a one-cycle latency, validsalida=1 and group_done=1; ptr stays at 0 and flush has no effect.
- Idle gaps (validEntrada==0) inside a group are allowed indefinitely and do not reorder lanes.

Test Plan:
- LANES=2, WIDTH=8: reset low, drive valid words 0xA1, 0xB2 on consecutive cycles. Required: the cycle after 0xB2 shows Salida[7:0]=0xA1, Salida[15:8]=0xB2, validsalida=2'b11, group_done=1 for exactly one cycle, and lane_idx=0.
- LANES=4: drive 0x11, 0x22, then 3 idle cycles, then 0x33, 0x44. Required: a single emission with Salida=0x44332211 and validsalida=4'hF; no emission occurs during the gap.
- LANES=4: drive 0x55, 0x66, then flush with no valid. Required: Salida=0x00006655, validsalida=4'b0011, group_done pulse, and lane_idx returns to 0.
- LANES=4: three words 0x01, 0x02, 0x03, then 0x04 with flush asserted on the same edge. Required: validsalida=4'hF and Salida=0x04030201, i.e. a single emission, not two.
- Assert reset asynchronously after 2 of 4 words, then release and drive 4 new words 0xC0..0xC3. Required: all outputs go to 0 immediately on reset; the next emission contains only 0xC3C2C1C0 with validsalida=4'hF.
- LANES=1: drive a continuous stream 0x10, 0x11, 0x12. Required: each word appears one cycle later with validsalida=1 and group_done=1 asserted every cycle.

Source files
------------

// File: rtl/demux_rr_n.sv
// demux_rr_n: round-robin 1-to-LANES demux. Input words are staged per lane
// and presented together once a group fills, or early on flush with a lane mask.

// Per-lane slice. It holds the staged word and its mask bit, and drives the
// lane output register.
module demux_rr_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,     // this lane is written on this edge
  input  logic             emit,    // group is emitted on this edge
  input  logic [WIDTH-1:0] din,
  output logic             mask_n,  // lane occupancy, including a write on this edge
  output logic [WIDTH-1:0] dout,
  output logic             vout
);
  logic [WIDTH-1:0] shadow;
  logic             mask;

  assign mask_n = mask | hit;

  // Stage the word, or release it on emission. A word written on the emitting
  // edge bypasses the shadow register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      mask   <= 1'b0;
      dout   <= '0;
      vout   <= 1'b0;
    end else begin
      vout <= 1'b0;
      if (emit) begin
        mask <= 1'b0;
        vout <= mask_n;
        dout <= !mask_n ? '0 : (hit ? din : shadow);
      end else if (hit) begin
        shadow <= din;
        mask   <= 1'b1;
      end
    end
  end
endmodule

module demux_rr_n #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WIDTH-1:0]                Entrada,
  input  logic                            validEntrada,
  input  logic                            flush,
  output logic [LANES*WIDTH-1:0]          Salida,
  output logic [LANES-1:0]                validsalida,
  output logic                            group_done,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] lane_idx
);
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

  logic [PTR_W-1:0]             ptr;
  logic [LANES-1:0]             hit;
  logic [LANES-1:0]             mask_n;
  logic [LANES-1:0][WIDTH-1:0]  lane_data;
  logic                         emit;

  // A group goes out when the last lane fills, or on flush if anything is staged.
  assign emit     = (validEntrada && (ptr == LAST)) || (flush && (|mask_n));
  assign Salida   = lane_data;
  assign lane_idx = ptr;

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      assign hit[i] = validEntrada && (ptr == PTR_W'(i));
      demux_rr_lane #(.WIDTH(WIDTH)) u_lane (
        .clk    (clk),
        .reset  (reset),
        .hit    (hit[i]),
        .emit   (emit),
        .din    (Entrada),
        .mask_n (mask_n[i]),
        .dout   (lane_data[i]),
        .vout   (validsalida[i])
      );
    end
  endgenerate

  // Write pointer and group pulse. Every emission rewinds the pointer to lane 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      group_done <= 1'b0;
    end else begin
      group_done <= emit;
      if (emit)              ptr <= '0;
      else if (validEntrada) ptr <= ptr + PTR_W'(1);
    end
  end
endmodule

// File: tb/tb_demux_rr_n.sv
// Directed bench for demux_rr_n, with instances for LANES = 2, 4 and 1.
module tb_demux_rr_n;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // LANES=2 instance
  logic [7:0]  e2 = '0;
  logic        v2 = 1'b0, f2 = 1'b0;
  logic [15:0] s2;
  logic [1:0]  vs2;
  logic        gd2;
  logic [0:0]  li2;
  // LANES=4 instance
  logic [7:0]  e4 = '0;
  logic        v4 = 1'b0, f4 = 1'b0;
  logic [31:0] s4;
  logic [3:0]  vs4;
  logic        gd4;
  logic [1:0]  li4;
  // LANES=1 instance
  logic [7:0]  e1 = '0;
  logic        v1 = 1'b0, f1 = 1'b0;
  logic [7:0]  s1;
  logic [0:0]  vs1;
  logic        gd1;
  logic [0:0]  li1;

  demux_rr_n #(.WIDTH(8), .LANES(2)) d2 (
    .clk(clk), .reset(reset), .Entrada(e2), .validEntrada(v2), .flush(f2),
    .Salida(s2), .validsalida(vs2), .group_done(gd2), .lane_idx(li2));
  demux_rr_n #(.WIDTH(8), .LANES(4)) d4 (
    .clk(clk), .reset(reset), .Entrada(e4), .validEntrada(v4), .flush(f4),
    .Salida(s4), .validsalida(vs4), .group_done(gd4), .lane_idx(li4));
  demux_rr_n #(.WIDTH(8), .LANES(1)) d1 (
    .clk(clk), .reset(reset), .Entrada(e1), .validEntrada(v1), .flush(f1),
    .Salida(s1), .validsalida(vs1), .group_done(gd1), .lane_idx(li1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [31:0] s, input logic [3:0] vs,
                      input logic gd, input logic [1:0] li);
    chk({tag, ".Salida"}, s4, s);
    chk({tag, ".valid"},  vs4, vs);
    chk({tag, ".done"},   gd4, gd);
    chk({tag, ".idx"},    li4, li);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst.s2", s2, 0);   chk("rst.vs2", vs2, 0); chk("rst.gd2", gd2, 0); chk("rst.li2", li2, 0);
    chk("rst.s4", s4, 0);   chk("rst.vs4", vs4, 0); chk("rst.gd4", gd4, 0); chk("rst.li4", li4, 0);
    chk("rst.s1", s1, 0);   chk("rst.vs1", vs1, 0); chk("rst.gd1", gd1, 0);
    tick();
    reset = 1'b1;

    // LANES=2: A1, B2 back to back
    v2 = 1'b1; e2 = 8'hA1; tick();
    chk("t1.idx_mid", li2, 1); chk("t1.valid_mid", vs2, 0); chk("t1.done_mid", gd2, 0);
    e2 = 8'hB2; tick();
    chk("t1.Salida", s2, 16'hB2A1); chk("t1.valid", vs2, 2'b11);
    chk("t1.done", gd2, 1); chk("t1.idx", li2, 0);
    v2 = 1'b0; tick();
    chk("t1.done_off", gd2, 0); chk("t1.valid_off", vs2, 0); chk("t1.hold", s2, 16'hB2A1);

    // LANES=4: 11, 22, gap of 3 idle cycles, 33, 44
    v4 = 1'b1; e4 = 8'h11; tick();
    e4 = 8'h22; tick();
    v4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2.gap", {vs4, gd4, li4}, {4'h0, 1'b0, 2'd2});
    end
    v4 = 1'b1; e4 = 8'h33; tick();
    chk4("t2.pre", 32'h0, 4'h0, 1'b0, 2'd3);
    e4 = 8'h44; tick();
    chk4("t2.full", 32'h44332211, 4'hF, 1'b1, 2'd0);

    // LANES=4: 55, 66, then flush alone
    e4 = 8'h55; tick();
    chk("t3.pulse_off", gd4, 0);
    e4 = 8'h66; tick();
    v4 = 1'b0; f4 = 1'b1; tick();
    chk4("t3.flush", 32'h00006655, 4'b0011, 1'b1, 2'd0);
    tick();  // flush with an empty mask: no emission
    chk4("t3.empty", 32'h00006655, 4'h0, 1'b0, 2'd0);
    f4 = 1'b0;

    // LANES=4: 01, 02, 03, then 04 together with flush
    v4 = 1'b1; e4 = 8'h01; tick();
    e4 = 8'h02; tick();
    e4 = 8'h03; tick();
    e4 = 8'h04; f4 = 1'b1; tick();
    chk4("t4.flushfull", 32'h04030201, 4'hF, 1'b1, 2'd0);
    // flush with a word at lane 0, then again next cycle (back to back)
    e4 = 8'h77; tick();
    chk4("t4.flush1", 32'h00000077, 4'b0001, 1'b1, 2'd0);
    e4 = 8'h88; tick();
    chk4("t4.b2b", 32'h00000088, 4'b0001, 1'b1, 2'd0);
    v4 = 1'b0; f4 = 1'b0; tick();
    chk4("t4.quiet", 32'h00000088, 4'h0, 1'b0, 2'd0);

    // Async reset after 2 of 4 words
    v4 = 1'b1; e4 = 8'hAA; tick();
    e4 = 8'hBB; tick();
    v4 = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk4("t5.async", 32'h0, 4'h0, 1'b0, 2'd0);
    chk("t5.s2", s2, 0);
    tick();
    reset = 1'b1;
    v4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e4 = 8'hC0 + 8'(k);
      tick();
    end
    chk4("t5.new", 32'hC3C2C1C0, 4'hF, 1'b1, 2'd0);
    v4 = 1'b0;

    // LANES=1: continuous stream
    v1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e1 = 8'h10 + 8'(k);
      tick();
      chk("t6.Salida", s1, 8'h10 + 8'(k));
      chk("t6.valid", vs1, 1);
      chk("t6.done", gd1, 1);
      chk("t6.idx", li1, 0);
    end
    v1 = 1'b0; f1 = 1'b1; tick();
    chk("t6.flush_valid", vs1, 0); chk("t6.flush_done", gd1, 0); chk("t6.hold", s1, 8'h12);
    f1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
